// File: rtl/ro_puf_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ro_puf_ctrl
//  Description : Ring-oscillator PUF controller. For each response bit it
//                applies a challenge-derived slice/pair selection, lets the
//                oscillator pair settle, counts rising edges of both
//                oscillators over a fixed window, drains the synchronizers
//                and records (cnt_a > cnt_b) as the response bit. The full
//                response word is published atomically with a DONE pulse.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    N_BITS   response bits per run (1..64)
//    WIN_CYC  measurement window per bit in clk cycles (>= 4)
//    CNT_W    edge-counter width (counters saturate at all-ones)
//  Ports
//    clk, rst            clock; asynchronous active-high reset
//    START, CHAL[7:0]    run request (sampled in IDLE) and challenge seed
//    RO_A, RO_B          oscillator outputs, asynchronous to clk
//    RO_EN               oscillator enable (both slices)
//    SEL_A, BX_A,
//    SEL_B, BX_B         slice path selects
//    PAIR_IDX[3:0]       oscillator pair select
//    BUSY                high whenever the controller is not idle
//    DONE                one-cycle pulse when RESP is updated
//    RESP[N_BITS-1:0]    last completed response word
//  Build option
//    RO_PUF_DBG_CNT_EN   adds DBG_CNT_A / DBG_CNT_B: the counts used by the
//                        most recent compare
// ============================================================================
module ro_puf_ctrl #(
    parameter int N_BITS  = 16,
    parameter int WIN_CYC = 1024,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              START,
    input  logic [7:0]        CHAL,
    input  logic              RO_A,
    input  logic              RO_B,
    output logic              RO_EN,
    output logic              SEL_A,
    output logic              BX_A,
    output logic              SEL_B,
    output logic              BX_B,
    output logic [3:0]        PAIR_IDX,
    output logic              BUSY,
    output logic              DONE,
    output logic [N_BITS-1:0] RESP
`ifdef RO_PUF_DBG_CNT_EN
    ,
    output logic [CNT_W-1:0]  DBG_CNT_A,
    output logic [CNT_W-1:0]  DBG_CNT_B
`endif
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    // Down-counter for phase durations; WIN_CYC >= 4 guarantees it can
    // also hold the SETTLE and DRAIN reload values.
    localparam int c_TMR_W = $clog2(WIN_CYC);

    localparam logic [c_TMR_W-1:0] c_SETTLE_LD = c_TMR_W'(3);
    localparam logic [c_TMR_W-1:0] c_MEAS_LD   = c_TMR_W'(WIN_CYC - 1);
    localparam logic [c_TMR_W-1:0] c_DRAIN_LD  = c_TMR_W'(2);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(N_BITS - 1);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_SETTLE  = 3'd1;
    localparam logic [2:0] c_ST_MEASURE = 3'd2;
    localparam logic [2:0] c_ST_DRAIN   = 3'd3;
    localparam logic [2:0] c_ST_COMPARE = 3'd4;
    localparam logic [2:0] c_ST_FIN     = 3'd5;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]         r_state;
    logic [c_TMR_W-1:0] r_tmr;
    logic [c_IDX_W-1:0] r_idx;
    logic [7:0]         r_chal;
    logic [7:0]         r_word;
    logic [N_BITS-1:0]  r_shadow;
    logic [N_BITS-1:0]  r_resp;
    logic               r_ro_en;
    logic               r_busy;
    logic               r_done;

    logic               r_a_sync1, r_a_sync2, r_a_dly;
    logic               r_b_sync1, r_b_sync2, r_b_dly;
    logic [CNT_W-1:0]   r_cnt_a;
    logic [CNT_W-1:0]   r_cnt_b;

    logic [7:0]         w_idx_ext;
    logic [7:0]         w_next_word;
    logic               w_counting;
    logic               w_clear;
    logic               w_edge_a;
    logic               w_edge_b;

    // Challenge word for the next bit: (seed + i + 1) mod 256
    assign w_idx_ext   = {{(8 - c_IDX_W){1'b0}}, r_idx};
    assign w_next_word = r_chal + w_idx_ext + 8'd1;

    // DRAIN keeps counting so edges still travelling through the
    // synchronizers when the window closes are not lost.
    assign w_counting = (r_state == c_ST_MEASURE) || (r_state == c_ST_DRAIN);
    assign w_clear    = (r_state == c_ST_SETTLE);

    assign w_edge_a = r_a_sync2 & ~r_a_dly;
    assign w_edge_b = r_b_sync2 & ~r_b_dly;

    // ------------------------------------------------------------------
    // Oscillator synchronizers (2 flops) plus edge-detect delay flop
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sync1 <= 1'b0;
            r_a_sync2 <= 1'b0;
            r_a_dly   <= 1'b0;
            r_b_sync1 <= 1'b0;
            r_b_sync2 <= 1'b0;
            r_b_dly   <= 1'b0;
        end else begin
            r_a_sync1 <= RO_A;
            r_a_sync2 <= r_a_sync1;
            r_a_dly   <= r_a_sync2;
            r_b_sync1 <= RO_B;
            r_b_sync2 <= r_b_sync1;
            r_b_dly   <= r_b_sync2;
        end
    end

    // ------------------------------------------------------------------
    // Saturating edge counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else if (w_clear) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else if (w_counting) begin
            if (w_edge_a && (r_cnt_a != '1)) begin
                r_cnt_a <= r_cnt_a + 1'b1;
            end
            if (w_edge_b && (r_cnt_b != '1)) begin
                r_cnt_b <= r_cnt_b + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_tmr    <= '0;
            r_idx    <= '0;
            r_chal   <= '0;
            r_word   <= '0;
            r_shadow <= '0;
            r_resp   <= '0;
            r_ro_en  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (START) begin
                        r_chal  <= CHAL;
                        r_word  <= CHAL;
                        r_idx   <= '0;
                        r_tmr   <= c_SETTLE_LD;
                        r_busy  <= 1'b1;
                        r_state <= c_ST_SETTLE;
                    end
                end

                c_ST_SETTLE: begin
                    if (r_tmr == '0) begin
                        r_tmr   <= c_MEAS_LD;
                        r_ro_en <= 1'b1;
                        r_state <= c_ST_MEASURE;
                    end else begin
                        r_tmr <= r_tmr - 1'b1;
                    end
                end

                c_ST_MEASURE: begin
                    if (r_tmr == '0) begin
                        r_tmr   <= c_DRAIN_LD;
                        r_ro_en <= 1'b0;
                        r_state <= c_ST_DRAIN;
                    end else begin
                        r_tmr <= r_tmr - 1'b1;
                    end
                end

                c_ST_DRAIN: begin
                    if (r_tmr == '0) begin
                        r_state <= c_ST_COMPARE;
                    end else begin
                        r_tmr <= r_tmr - 1'b1;
                    end
                end

                c_ST_COMPARE: begin
                    // Strict compare: a tie yields 0
                    r_shadow[r_idx] <= (r_cnt_a > r_cnt_b);
                    if (r_idx == c_LAST_IDX) begin
                        r_state <= c_ST_FIN;
                    end else begin
                        r_idx   <= r_idx + c_IDX_W'(1);
                        r_word  <= w_next_word;
                        r_tmr   <= c_SETTLE_LD;
                        r_state <= c_ST_SETTLE;
                    end
                end

                c_ST_FIN: begin
                    // Whole word published at once, with the DONE pulse
                    r_resp  <= r_shadow;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    r_ro_en <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

`ifdef RO_PUF_DBG_CNT_EN
    logic [CNT_W-1:0] r_dbg_cnt_a;
    logic [CNT_W-1:0] r_dbg_cnt_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dbg_cnt_a <= '0;
            r_dbg_cnt_b <= '0;
        end else if (r_state == c_ST_COMPARE) begin
            r_dbg_cnt_a <= r_cnt_a;
            r_dbg_cnt_b <= r_cnt_b;
        end
    end

    assign DBG_CNT_A = r_dbg_cnt_a;
    assign DBG_CNT_B = r_dbg_cnt_b;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign RO_EN    = r_ro_en;
    assign SEL_A    = r_word[0];
    assign BX_A     = r_word[1];
    assign SEL_B    = r_word[2];
    assign BX_B     = r_word[3];
    assign PAIR_IDX = r_word[7:4];
    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign RESP     = r_resp;

endmodule
`default_nettype wire

// File: doc/ro_puf_ctrl.md
RO_PUF_CTRL -- requirements
Module: ro_puf_ctrl

Interface
REQ-001 Parameter N_BITS, default 16: response bits produced per run (1..64).
REQ-002 Parameter WIN_CYC, default 1024: measurement window per bit, in clk cycles (>=4).
REQ-003 Parameter CNT_W, default 16: edge-counter width.
REQ-004 Port clk, input, 1: single system clock; all state on rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port START, input, 1: run request; sampled in IDLE only.
REQ-007 Port CHAL, input, 8: challenge seed; latched on accepted START.
REQ-008 Port RO_A, input, 1: oscillator A output; asynchronous to clk.
REQ-009 Port RO_B, input, 1: oscillator B output; asynchronous to clk.
REQ-010 Ports RO_EN, output, 1: oscillator enable, drives inverter-chain feedback gate of both slices.
REQ-011 Ports SEL_A, BX_A, SEL_B, BX_B, output, 1 each: slice path selects for A and B.
REQ-012 Port PAIR_IDX, output, 4: RO pair select to external pair mux.
REQ-013 Port BUSY, output, 1: high in any state other than IDLE.
REQ-014 Port DONE, output, 1: one-cycle pulse when RESP is updated.
REQ-015 Port RESP, output, N_BITS: last completed response word.

Function
REQ-016 FSM states IDLE, SETTLE, MEASURE, DRAIN, COMPARE, FIN.
REQ-017 IDLE with START=1: latch CHAL, clear bit index i, go SETTLE; START while BUSY ignored.
REQ-018 Challenge word for bit i: c = (CHAL_latched + i) mod 256; SEL_A=c[0], BX_A=c[1], SEL_B=c[2], BX_B=c[3], PAIR_IDX=c[7:4]; held stable SETTLE through COMPARE.
REQ-019 SETTLE: exactly 4 cycles, RO_EN=0, both edge counters cleared.
REQ-020 MEASURE: exactly WIN_CYC cycles, RO_EN=1.
REQ-021 DRAIN: exactly 3 cycles, RO_EN=0, counting continues to flush synchronizers.
REQ-022 COMPARE: 1 cycle; bit i = 1 if cntA > cntB, else 0 (tie gives 0); stored in shadow bit i.
REQ-023 After COMPARE: i < N_BITS-1 -> i+1, SETTLE; else FIN.
REQ-024 FIN: 1 cycle; RESP <= shadow, DONE=1; next state IDLE.
REQ-025 Each RO input passes a 2-flop synchronizer plus one delay flop; rising edge counted when sync2=1 and delayed=0, only in MEASURE or DRAIN.
REQ-026 Counters saturate at 2^CNT_W-1; no wrap.
REQ-027 Latency: DONE high exactly N_BITS*(WIN_CYC+8)+1 cycles after the START-sampling edge.
REQ-028 RESP holds its value between runs; never partially updated.

Reset
REQ-029 rst=1 forces immediately: state IDLE, RO_EN=0, BUSY=0, DONE=0, RESP=0, all selects/PAIR_IDX=0, counters, i, shadow, synchronizers =0.
REQ-030 Reset mid-run aborts; no DONE pulse; RESP stays 0 after release.

Configuration
REQ-031 Macro RO_PUF_DBG_CNT_EN: when defined, adds outputs DBG_CNT_A and DBG_CNT_B (CNT_W each), loaded in COMPARE with the compared counts, reset to 0; when undefined, ports absent and function otherwise identical.

Verification
REQ-032 N_BITS=4, WIN_CYC=16, RO_A toggling every clk, RO_B every 4 clk, START pulse -> DONE at cycle 97, RESP=4'b1111.
REQ-033 Same but RO_B faster than RO_A -> RESP=4'b0000; RO_A=RO_B identical waveform -> RESP=4'b0000 (tie).
REQ-034 CHAL=8'hFE, N_BITS=4 -> challenge words FE, FF, 00, 01 in order; PAIR_IDX F, F, 0, 0; SEL_A/BX_A follow c[0]/c[1].
REQ-035 CNT_W=4, RO_A toggling every clk for WIN_CYC=64 -> counter holds 15, no wrap.
REQ-036 START re-pulsed while BUSY -> ignored, single DONE; rst asserted in MEASURE -> RO_EN=0 same cycle, IDLE, no DONE, RESP=0.
